// File: rtl/load_queue_pq.sv
// In-order-allocate / out-of-order-issue load queue with dual dispatch and dual commit.
// Optional flush port and queue clear are enabled with the LQ_FLUSH_EN macro.
module load_queue_pq #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ROB_W  = 6,
    parameter int unsigned PREG_W = 6,
    parameter int unsigned IMM_W  = 32,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_valid_1,
    input  logic              disp_valid_2,
    input  logic [PREG_W-1:0] disp_base_reg_1,
    input  logic [PREG_W-1:0] disp_base_reg_2,
    input  logic [IMM_W-1:0]  disp_offset_1,
    input  logic [IMM_W-1:0]  disp_offset_2,
    input  logic [ROB_W-1:0]  disp_rob_idx_1,
    input  logic [ROB_W-1:0]  disp_rob_idx_2,
    output logic              disp_stall,
    output logic [IDX_W-1:0]  disp_lq_idx_1,
    output logic [IDX_W-1:0]  disp_lq_idx_2,
    input  logic              agu_valid_1,
    input  logic              agu_valid_2,
    input  logic [IDX_W-1:0]  agu_lq_idx_1,
    input  logic [IDX_W-1:0]  agu_lq_idx_2,
    input  logic [ADDR_W-1:0] agu_addr_1,
    input  logic [ADDR_W-1:0] agu_addr_2,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [ROB_W-1:0]  mem_req_rob_idx,
    output logic [IDX_W-1:0]  mem_req_lq_idx,
    input  logic              mem_resp_valid,
    input  logic [IDX_W-1:0]  mem_resp_lq_idx,
    input  logic              commit_1,
    input  logic              commit_2,
`ifdef LQ_FLUSH_EN
    input  logic              flush,
`endif
    output logic              lq_full,
    output logic              lq_empty,
    output logic [IDX_W:0]    lq_count
);

    localparam int unsigned CntW = IDX_W + 1;
    localparam logic [IDX_W:0] DepthC = CntW'(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  addr_rdy_q, addr_rdy_d;
    logic [DEPTH-1:0]  issued_q, issued_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [PREG_W-1:0] base_reg_q [DEPTH];
    logic [PREG_W-1:0] base_reg_d [DEPTH];
    logic [IMM_W-1:0]  offset_q [DEPTH];
    logic [IMM_W-1:0]  offset_d [DEPTH];
    logic [ROB_W-1:0]  rob_idx_q [DEPTH];
    logic [ROB_W-1:0]  rob_idx_d [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [IDX_W:0]    head_q, head_d;
    logic [IDX_W:0]    tail_q, tail_d;

    logic              flush_w;
    logic [IDX_W:0]    count;
    logic [IDX_W:0]    free_slots;
    logic [1:0]        n_req;
    logic [1:0]        n_free;
    logic [IDX_W-1:0]  tail_idx, head_idx, head_idx_p1;
    logic              alloc_ok;
    logic              free_1, free_2;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  scan_idx;
    logic              mem_fire;

`ifdef LQ_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Occupancy and dispatch allocation; the free-slot check uses the pre-commit count.
    always_comb begin
        count         = tail_q - head_q;
        free_slots    = DepthC - count;
        n_req         = {1'b0, disp_valid_1} + {1'b0, disp_valid_2};
        tail_idx      = tail_q[IDX_W-1:0];
        head_idx      = head_q[IDX_W-1:0];
        head_idx_p1   = head_idx + 1'b1;
        disp_stall    = CntW'(n_req) > free_slots;
        disp_lq_idx_1 = tail_idx;
        disp_lq_idx_2 = disp_valid_1 ? tail_idx + 1'b1 : tail_idx;
        alloc_ok      = !disp_stall && !flush_w;
        lq_count      = count;
        lq_full       = (count == DepthC);
        lq_empty      = (count == '0);
    end

    // Oldest-first scan from head for an address-ready, not-yet-issued entry.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_idx + IDX_W'(i);
            if (!sel_found && valid_q[scan_idx] && addr_rdy_q[scan_idx] &&
                !issued_q[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
        mem_req_valid   = sel_found && !flush_w;
        mem_req_addr    = sel_found ? addr_q[sel_idx] : '0;
        mem_req_rob_idx = sel_found ? rob_idx_q[sel_idx] : '0;
        mem_req_lq_idx  = sel_found ? sel_idx : '0;
        mem_fire        = mem_req_valid && mem_req_ready;
    end

    // A not-done head blocks both commit bits; commit_2 needs commit_1.
    always_comb begin
        free_1 = commit_1 && valid_q[head_idx] && done_q[head_idx] && !flush_w;
        free_2 = free_1 && commit_2 && valid_q[head_idx_p1] && done_q[head_idx_p1];
        n_free = {1'b0, free_1} + {1'b0, free_2};
    end

    always_comb begin
        valid_d    = valid_q;
        addr_rdy_d = addr_rdy_q;
        issued_d   = issued_q;
        done_d     = done_q;
        base_reg_d = base_reg_q;
        offset_d   = offset_q;
        rob_idx_d  = rob_idx_q;
        addr_d     = addr_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (alloc_ok) begin
            if (disp_valid_1) begin
                valid_d[disp_lq_idx_1]    = 1'b1;
                addr_rdy_d[disp_lq_idx_1] = 1'b0;
                issued_d[disp_lq_idx_1]   = 1'b0;
                done_d[disp_lq_idx_1]     = 1'b0;
                base_reg_d[disp_lq_idx_1] = disp_base_reg_1;
                offset_d[disp_lq_idx_1]   = disp_offset_1;
                rob_idx_d[disp_lq_idx_1]  = disp_rob_idx_1;
                addr_d[disp_lq_idx_1]     = '0;
            end
            if (disp_valid_2) begin
                valid_d[disp_lq_idx_2]    = 1'b1;
                addr_rdy_d[disp_lq_idx_2] = 1'b0;
                issued_d[disp_lq_idx_2]   = 1'b0;
                done_d[disp_lq_idx_2]     = 1'b0;
                base_reg_d[disp_lq_idx_2] = disp_base_reg_2;
                offset_d[disp_lq_idx_2]   = disp_offset_2;
                rob_idx_d[disp_lq_idx_2]  = disp_rob_idx_2;
                addr_d[disp_lq_idx_2]     = '0;
            end
            tail_d = tail_q + CntW'(n_req);
        end

        // Port 2 is applied last so it wins on a same-index collision.
        if (agu_valid_1 && valid_q[agu_lq_idx_1] && !flush_w) begin
            addr_d[agu_lq_idx_1]     = agu_addr_1;
            addr_rdy_d[agu_lq_idx_1] = 1'b1;
        end
        if (agu_valid_2 && valid_q[agu_lq_idx_2] && !flush_w) begin
            addr_d[agu_lq_idx_2]     = agu_addr_2;
            addr_rdy_d[agu_lq_idx_2] = 1'b1;
        end

        if (mem_fire) begin
            issued_d[sel_idx] = 1'b1;
        end
        if (mem_resp_valid && valid_q[mem_resp_lq_idx] && !flush_w) begin
            done_d[mem_resp_lq_idx] = 1'b1;
        end

        if (free_1) begin
            valid_d[head_idx]    = 1'b0;
            addr_rdy_d[head_idx] = 1'b0;
            issued_d[head_idx]   = 1'b0;
            done_d[head_idx]     = 1'b0;
        end
        if (free_2) begin
            valid_d[head_idx_p1]    = 1'b0;
            addr_rdy_d[head_idx_p1] = 1'b0;
            issued_d[head_idx_p1]   = 1'b0;
            done_d[head_idx_p1]     = 1'b0;
        end
        head_d = head_q + CntW'(n_free);

        if (flush_w) begin
            valid_d    = '0;
            addr_rdy_d = '0;
            issued_d   = '0;
            done_d     = '0;
            head_d     = '0;
            tail_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            addr_rdy_q <= '0;
            issued_q   <= '0;
            done_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                base_reg_q[i] <= '0;
                offset_q[i]   <= '0;
                rob_idx_q[i]  <= '0;
                addr_q[i]     <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            addr_rdy_q <= addr_rdy_d;
            issued_q   <= issued_d;
            done_q     <= done_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            base_reg_q <= base_reg_d;
            offset_q   <= offset_d;
            rob_idx_q  <= rob_idx_d;
            addr_q     <= addr_d;
        end
    end

endmodule
